// File: rtl/mips_bus_pkg.sv
// Shared types for the bus-based MIPS control sequencer.
// State encoding is visible on the debug port, so the values are fixed.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALTED    = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mips_bus_sequencer_if.sv
// Avalon-style single memory port shared by instruction fetch and load/store.
interface mips_bus_sequencer_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/wait_timeout_counter.sv
// Counts consecutive stalled cycles of one bus access and flags the cycle
// whose stall would reach WAIT_TIMEOUT. WAIT_TIMEOUT = 0 disables the limit.
module wait_timeout_counter #(
  parameter int WAIT_TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [31:0] LIM_M1  = 32'(WAIT_TIMEOUT - 1);
  localparam bit          ENABLED = (WAIT_TIMEOUT != 0);

  logic [31:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + 32'd1;
  end

  // Fires on the stalled cycle that completes the allowed budget, so the
  // sequencer leaves the access on that same edge.
  assign expired = ENABLED && inc && (count == LIM_M1);

endmodule

// File: rtl/mips_bus_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WRITEBACK sequencer driving one shared
// memory port and the datapath strobes of the bus-based MIPS core.
module mips_bus_sequencer
  import mips_bus_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           store_data,
  input  logic [3:0]            store_be,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  writes_reg,
  input  logic                  halt_req,
  mips_bus_sequencer_if.master  bus,
  output logic [31:0]           instr,
  output logic [31:0]           load_data,
  output logic                  ir_write,
  output logic                  load_valid,
  output logic                  alu_en,
  output logic                  reg_write,
  output logic                  pc_en,
  output logic                  active,
  output logic                  bus_error,
  output logic [2:0]            state
);

  state_t state_q, state_d;
  logic   mem_is_load;
  logic   in_access;
  logic   stall;
  logic   expired;
  logic   fetch_done;
  logic   load_done;

  assign in_access  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign stall      = in_access && bus.waitrequest;
  assign fetch_done = (state_q == ST_FETCH) && !bus.waitrequest;
  assign load_done  = (state_q == ST_MEM) && mem_is_load && !bus.waitrequest;

  wait_timeout_counter #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_access),
    .inc     (stall),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (expired)               state_d = ST_ERROR;
        else if (!bus.waitrequest) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_load && is_store)      state_d = ST_ERROR;
        else if (is_load ^ is_store)  state_d = ST_MEM;
        else                          state_d = ST_WRITEBACK;
      end
      ST_MEM: begin
        if (expired)               state_d = ST_ERROR;
        else if (!bus.waitrequest) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = halt_req ? ST_HALTED : ST_FETCH;
      ST_HALTED:    state_d = ST_HALTED;
      ST_ERROR:     state_d = ST_ERROR;
      default:      state_d = ST_ERROR;
    endcase
  end

  // Reset clears the latches too, so an interrupted access leaves no partial instr/load_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      mem_is_load <= 1'b0;
      instr       <= '0;
      load_data   <= '0;
      ir_write    <= 1'b0;
      load_valid  <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_write   <= fetch_done;
      load_valid <= load_done;
      if (state_q == ST_EXEC) mem_is_load <= is_load;
      if (fetch_done)         instr       <= bus.readdata;
      if (load_done)          load_data   <= bus.readdata;
      if (state_d == ST_ERROR) bus_error  <= 1'b1;
    end
  end

  // Bus strobes decode purely from the registered state, so reset drops them at once.
  always_comb begin
    bus.address    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = '0;
    bus.writedata  = '0;
    case (state_q)
      ST_FETCH: begin
        bus.address    = pc;
        bus.read       = 1'b1;
        bus.byteenable = BE_WORD;
      end
      ST_MEM: begin
        bus.address = mem_addr & 32'hFFFF_FFFC;
        if (mem_is_load) begin
          bus.read       = 1'b1;
          bus.byteenable = BE_WORD;
        end else begin
          bus.write      = 1'b1;
          bus.byteenable = store_be;
          bus.writedata  = store_data;
        end
      end
      default: ;
    endcase
  end

  assign alu_en    = (state_q == ST_EXEC);
  assign pc_en     = (state_q == ST_WRITEBACK);
  assign reg_write = (state_q == ST_WRITEBACK) && writes_reg;
  assign active    = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXEC)  || (state_q == ST_MEM)    ||
                     (state_q == ST_WRITEBACK);
  assign state     = state_q;

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Scoreboard bench for mips_bus_sequencer: stimulus queues expected bus and
// strobe events, a negedge monitor pops and compares them as they appear.
module tb_mips_bus_sequencer;
  import mips_bus_pkg::*;

  localparam int K_RD = 0, K_WR = 1, K_IR = 2, K_LV = 3, K_WB = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0, mem_addr = '0, store_data = '0;
  logic [3:0]  store_be = '0;
  logic        is_load = 1'b0, is_store = 1'b0, writes_reg = 1'b0, halt_req = 1'b0;
  logic [31:0] instr, load_data;
  logic        ir_write, load_valid, alu_en, reg_write, pc_en, active, bus_error;
  logic [2:0]  state;

  mips_bus_sequencer_if bus ();

  mips_bus_sequencer #(.WAIT_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .store_be   (store_be),
    .is_load    (is_load),
    .is_store   (is_store),
    .writes_reg (writes_reg),
    .halt_req   (halt_req),
    .bus        (bus),
    .instr      (instr),
    .load_data  (load_data),
    .ir_write   (ir_write),
    .load_valid (load_valid),
    .alu_en     (alu_en),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .active     (active),
    .bus_error  (bus_error),
    .state      (state)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.be = be;
    sb.push_back(e);
  endtask

  task automatic take(input int kind, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none", kind, addr, data);
    end else begin
      e = sb.pop_front();
      check("evt_kind", kind, e.kind);
      check("evt_addr", addr, e.addr);
      check("evt_data", data, e.data);
      check("evt_be", {28'b0, be}, {28'b0, e.be});
    end
  endtask

  // Memory responder: per-access programmed stalls; junk data while stalled.
  int          fetch_waits = 0, mem_waits = 0, stall_cnt = 0;
  logic [31:0] fetch_word = '0, load_word = '0;
  logic        acc_prev = 1'b0;

  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_prev && bus.waitrequest) stall_cnt++;
      else                             stall_cnt = 0;
      acc_prev = bus.read || bus.write;
      bus.waitrequest = acc_prev &&
                        (stall_cnt < ((bus.address == pc) ? fetch_waits : mem_waits));
      bus.readdata = bus.waitrequest ? 32'h1111_1111 :
                     ((bus.address == pc) ? fetch_word : load_word);
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      check("rw_exclusive", {31'b0, bus.read & bus.write}, 32'd0);
      if ((bus.read || bus.write) && !bus.waitrequest)
        take(bus.write ? K_WR : K_RD, bus.address, bus.write ? bus.writedata : 32'd0,
             bus.byteenable);
      if (ir_write)   take(K_IR, 32'd0, instr, 4'd0);
      if (load_valid) take(K_LV, 32'd0, load_data, 4'd0);
      if (pc_en)      take(K_WB, 32'd0, {31'b0, reg_write}, 4'd0);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_strobes", {25'b0, bus.read, bus.write, ir_write, load_valid, reg_write, pc_en, active},
          32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_bus_error", {31'b0, bus_error}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  int act_cyc, acc_cyc, early;

  task automatic run_to_stop(input int limit);
    bit stopped = 0;
    act_cyc = 0; acc_cyc = 0; early = 0;
    for (int i = 0; i < limit && !stopped; i++) begin
      @(negedge clk);
      if (active) act_cyc++;
      if (bus.read || bus.write) acc_cyc++;
      if (state == 3'd1 && bus.waitrequest && instr != 32'd0) early++;
      if (state == 3'd6 || state == 3'd7) stopped = 1;
    end
    if (!stopped) check("stop_bound", {29'b0, state}, 32'd6);
  endtask

  task automatic setup(input logic [31:0] p, input logic [31:0] fw, input int fwt,
                       input logic ld, input logic st, input logic wr);
    pc = p; fetch_word = fw; fetch_waits = fwt;
    is_load = ld; is_store = st; writes_reg = wr; halt_req = 1'b1;
  endtask

  initial begin
    // Zero-wait ALU instruction
    setup(32'hBFC0_0000, 32'h0022_1820, 0, 1'b0, 1'b0, 1'b1);
    push(K_RD, 32'hBFC0_0000, 32'd0, 4'hF);
    push(K_IR, 32'd0, 32'h0022_1820, 4'd0);
    push(K_WB, 32'd0, 32'd1, 4'd0);
    do_reset();
    run_to_stop(40);
    check("alu_active_cycles", act_cyc, 4);
    check("alu_read_cycles", acc_cyc, 1);
    check("alu_halted_state", {29'b0, state}, 32'd6);

    // Fetch stalled three cycles
    setup(32'h0040_0000, 32'h8C22_0004, 3, 1'b0, 1'b0, 1'b1);
    push(K_RD, 32'h0040_0000, 32'd0, 4'hF);
    push(K_IR, 32'd0, 32'h8C22_0004, 4'd0);
    push(K_WB, 32'd0, 32'd1, 4'd0);
    do_reset();
    run_to_stop(40);
    check("stall_read_cycles", acc_cyc, 4);
    check("stall_early_capture", early, 0);
    check("stall_instr", instr, 32'h8C22_0004);

    // Unaligned load with two waits
    setup(32'h0000_0100, 32'h8C22_1003, 0, 1'b1, 1'b0, 1'b1);
    mem_addr = 32'h0000_1003; load_word = 32'hDEAD_BEEF; mem_waits = 2;
    push(K_RD, 32'h0000_0100, 32'd0, 4'hF);
    push(K_IR, 32'd0, 32'h8C22_1003, 4'd0);
    push(K_RD, 32'h0000_1000, 32'd0, 4'hF);
    push(K_LV, 32'd0, 32'hDEAD_BEEF, 4'd0);
    push(K_WB, 32'd0, 32'd1, 4'd0);
    do_reset();
    run_to_stop(40);
    check("load_access_cycles", acc_cyc, 4);
    check("load_data_final", load_data, 32'hDEAD_BEEF);

    // Halfword store, no register write
    setup(32'h0000_0200, 32'hA443_0006, 0, 1'b0, 1'b1, 1'b0);
    mem_addr = 32'h0000_2006; store_data = 32'h0000_ABCD; store_be = 4'b0011; mem_waits = 1;
    push(K_RD, 32'h0000_0200, 32'd0, 4'hF);
    push(K_IR, 32'd0, 32'hA443_0006, 4'd0);
    push(K_WR, 32'h0000_2004, 32'h0000_ABCD, 4'b0011);
    push(K_WB, 32'd0, 32'd0, 4'd0);
    do_reset();
    run_to_stop(40);
    check("store_access_cycles", acc_cyc, 3);

    // Stays quiet in HALTED
    begin
      int noisy = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.read || bus.write || ir_write || load_valid || reg_write || pc_en ||
            alu_en || active) noisy++;
      end
      check("halted_quiet_cycles", noisy, 0);
      check("halted_state", {29'b0, state}, 32'd6);
    end

    // Illegal load+store decode
    setup(32'h0000_0280, 32'h0000_0000, 0, 1'b1, 1'b1, 1'b1);
    push(K_RD, 32'h0000_0280, 32'd0, 4'hF);
    push(K_IR, 32'd0, 32'h0000_0000, 4'd0);
    do_reset();
    run_to_stop(40);
    check("illegal_state", {29'b0, state}, 32'd7);
    check("illegal_bus_error", {31'b0, bus_error}, 32'd1);

    // Stuck waitrequest hits the timeout
    setup(32'h0000_0300, 32'h0000_0000, 1000, 1'b0, 1'b0, 1'b1);
    do_reset();
    run_to_stop(40);
    check("timeout_read_cycles", acc_cyc, 4);
    check("timeout_state", {29'b0, state}, 32'd7);
    check("timeout_bus_error", {31'b0, bus_error}, 32'd1);
    check("timeout_read_low", {31'b0, bus.read}, 32'd0);
    check("timeout_active", {31'b0, active}, 32'd0);

    // Reset in the middle of a stalled fetch, then refetch
    setup(32'h0000_0400, 32'h0000_1820, 1000, 1'b0, 1'b0, 1'b1);
    do_reset();
    @(negedge clk); @(negedge clk);
    check("midfetch_read_before", {31'b0, bus.read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midfetch_read_dropped", {31'b0, bus.read}, 32'd0);
    check("midfetch_state", {29'b0, state}, 32'd0);
    check("midfetch_instr", instr, 32'd0);
    fetch_waits = 0;
    push(K_RD, 32'h0000_0400, 32'd0, 4'hF);
    push(K_IR, 32'd0, 32'h0000_1820, 4'd0);
    push(K_WB, 32'd0, 32'd1, 4'd0);
    @(posedge clk); #1 reset = 1'b0;
    run_to_stop(40);
    check("refetch_state", {29'b0, state}, 32'd6);

    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
